// File: rtl/decodificador_pkg.sv
// Shared types and helpers for the Gray-input conditioning path.
// Holds the conditioner FSM states, the error-counter width and a popcount.
package decodificador_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST,
      STABLE,
      SETTLING
   } estado_e;

   localparam int ERR_COUNT_W = 8;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/acondicionador_entrada_gray_sincronizador.sv
// N-bit multi-stage synchroniser for asynchronous board inputs.
// Each bit passes through SYNC_STAGES flops; reusable for any level input.
module sincronizador_nff #(
   parameter int N_BITS      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_BITS-1:0] d_in,
   output logic [N_BITS-1:0] d_out
);

   logic [SYNC_STAGES-1:0][N_BITS-1:0] etapa_d;
   logic [SYNC_STAGES-1:0][N_BITS-1:0] etapa_q;

   always_comb begin
      etapa_d[0] = d_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         etapa_d[i] = etapa_q[i-1];
      end
   end

   // NOTE: the whole chain is reset, so the first words after reset are a known 0, not X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         etapa_q <= '0;
      end else begin
         etapa_q <= etapa_d;
      end
   end

   assign d_out = etapa_q[SYNC_STAGES-1];

endmodule

// File: rtl/acondicionador_entrada_gray.sv
// Synchronises and word-debounces the Gray switch bank ahead of the decoder,
// flagging committed changes that are not single-bit steps.
module acondicionador_entrada_gray
   import decodificador_pkg::*;
#(
   parameter int N_BITS          = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_BITS-1:0]      sw_in,
   input  logic                   clear_err,
   output logic [N_BITS-1:0]      gray_out,
   output logic                   valid,
   output logic                   change,
   output logic                   gray_error,
   output logic [ERR_COUNT_W-1:0] err_count
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BITS-1:0] s;

   sincronizador_nff #(
      .N_BITS      (N_BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sincronizador (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (sw_in),
      .d_out (s)
   );

   estado_e                state_d, state_q;
   logic [N_BITS-1:0]      cand_d, cand_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q, cnt_inc;
   logic [N_BITS-1:0]      gray_out_d, gray_out_q;
   logic                   valid_d, valid_q;
   logic                   change_d, change_q;
   logic                   gray_error_d, gray_error_q;
   logic [ERR_COUNT_W-1:0] err_count_d, err_count_q;

   // The window counter parks at its terminal value instead of wrapping.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch appears.
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      gray_out_d   = gray_out_q;
      valid_d      = valid_q;
      change_d     = 1'b0;
      gray_error_d = 1'b0;

      unique case (state_q)
         WAIT_FIRST: begin
            if (s != cand_q) begin
               cand_d = s;
               cnt_d  = '0;
            end else if (cnt_q == CNT_MAX) begin
               gray_out_d = cand_q;
               valid_d    = 1'b1;
               change_d   = 1'b1;
               state_d    = STABLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         STABLE: begin
            if (s != gray_out_q) begin
               cand_d  = s;
               cnt_d   = '0;
               state_d = SETTLING;
            end
         end
         SETTLING: begin
            if (s == gray_out_q) begin
               cnt_d   = '0;
               state_d = STABLE;
            end else if (s != cand_q) begin
               cand_d = s;
               cnt_d  = '0;
            end else if (cnt_q == CNT_MAX) begin
               gray_out_d   = cand_q;
               change_d     = 1'b1;
               gray_error_d = (popcount(32'(cand_q ^ gray_out_q)) != 1);
               state_d      = STABLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = WAIT_FIRST;
      endcase

      // Clear wins first, then the pending error pulse is counted on top.
      err_count_d = clear_err ? '0 : err_count_q;
      if (gray_error_q && (err_count_d != '1)) begin
         err_count_d = err_count_d + ERR_COUNT_W'(1);
      end
   end

   // NOTE: sequential state uses <= so all flops update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_FIRST;
         cand_q       <= '0;
         cnt_q        <= '0;
         gray_out_q   <= '0;
         valid_q      <= 1'b0;
         change_q     <= 1'b0;
         gray_error_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         gray_out_q   <= gray_out_d;
         valid_q      <= valid_d;
         change_q     <= change_d;
         gray_error_q <= gray_error_d;
         err_count_q  <= err_count_d;
      end
   end

   assign gray_out   = gray_out_q;
   assign valid      = valid_q;
   assign change     = change_q;
   assign gray_error = gray_error_q;
   assign err_count  = err_count_q;

endmodule
